kronos_dbus_bridge: RTL
=======================

# kronos_dbus_bridge

Data-side bus bridge directly downstream of the Kronos execute stage's data port. It accepts the core's level-held request / single-cycle acknowledge transaction and runs it as a registered Wishbone-classic master cycle. It adds a bus timeout and error reporting, and completes zero-mask writes locally, so the core never hangs on a dead or faulting slave.

## Interface
- TIMEOUT_CYCLES, 16: maximum bus cycles with cyc high before forced termination; 0 disables the timeout.
- ERR_RDATA, 32'hDEAD_BEEF: value returned on data_rd_data for an errored or timed-out access.
- clk  in  1  core clock; all logic on its rising edge.
- rstz  in  1  asynchronous, active-low reset.
- data_addr  in  32  core request address.
- data_wr_data  in  32  core write data.
- data_mask  in  4  byte-lane enables.
- data_wr_en  in  1  1 = write, 0 = read.
- data_req  in  1  request, held high until data_ack; fields stable while high.
- data_ack  out  1  one-cycle completion pulse to core.
- data_rd_data  out  32  read data, valid while data_ack=1.
- wb_adr_o  out  32  bus address, word-aligned ({data_addr[31:2],2'b00}).
- wb_dat_o  out  32  bus write data.
- wb_sel_o  out  4  bus byte selects.
- wb_we_o  out  1  bus write enable.
- wb_cyc_o, wb_stb_o  out  1 each  bus cycle/strobe; always equal.
- wb_dat_i  in  32  bus read data.
- wb_ack_i  in  1  slave acknowledge.
- wb_err_i  in  1  slave error.
- err_vld  out  1  one-cycle pulse on an errored or timed-out access.
- err_addr  out  32  data_addr of the most recent errored access.
- err_timeout  out  1  1 = the last error was a timeout, 0 = wb_err_i.
- err_count  out  8  saturating count of errors since reset.

## Operation
- States: IDLE, BUS, RESP.
- IDLE, data_req=1, and not (data_wr_en=1 and data_mask=0): register address, data, sel and we onto the bus; set cyc/stb; clear the timeout counter; go to BUS.
- IDLE, zero-mask write: no bus cycle; go to RESP with data_ack next cycle and data_rd_data=0.
- BUS, wb_err_i=1: error termination, even if wb_ack_i=1 in the same cycle.
- BUS, wb_ack_i=1 with no error: capture wb_dat_i for reads (0 for writes); drop cyc/stb; go to RESP.
- BUS, no ack/err, counter==TIMEOUT_CYCLES-1, TIMEOUT_CYCLES!=0: timeout termination. Otherwise the counter increments.
- An ack in the expiry cycle wins over the timeout.
- Error/timeout termination: drop cyc/stb; data_rd_data=ERR_RDATA; pulse err_vld with data_ack; update err_addr and err_timeout; err_count increments, saturating at 255. Go to RESP.
- RESP: data_ack=1 for exactly one cycle; go to IDLE.
- data_req seen during RESP belongs to the finishing access. A new request is sampled in IDLE only.
- wb_* outputs are registered and never change while cyc is high.

## Timing
- Reset values: all outputs 0, state IDLE, counter 0.
- Reset is asynchronous. Reset mid-transaction drops cyc/stb immediately, and no ack is issued for the aborted access.
- Minimum read/write latency: req sampled at edge 0; cyc high in cycle 1; slave ack in cycle 1; data_ack in cycle 2.
- Back-to-back: next bus cycle starts at cycle 4. Sustained throughput is one access per 3 cycles with zero-wait slaves.
- Zero-mask write: data_ack in cycle 1 after the sampling edge.
- Timeout: with TIMEOUT_CYCLES=N, cyc is high for exactly N cycles, then data_ack and err_vld pulse in the next cycle.
- Counter width is $clog2(TIMEOUT_CYCLES+1) bits.
- data_rd_data holds its value after the ack until the next completion.

## Test plan
- Read of 0x1000_0004, mask 4'hF, slave acks in the first cycle with 0xCAFE_F00D -> cyc high 1 cycle; data_ack at cycle 2 with data_rd_data=0xCAFE_F00D; err_vld never asserts.
- Write of 0x1234_5678 to 0x20, mask 4'b0011, slave with 3 wait states -> wb_sel_o=4'b0011, wb_we_o=1, wb_dat_o=0x1234_5678 held 4 cycles; single data_ack pulse.
- TIMEOUT_CYCLES=4, slave never responds, read at 0x40 -> cyc high 4 cycles; data_ack and err_vld pulse together; data_rd_data=0xDEAD_BEEF; err_addr=0x40; err_timeout=1; err_count=1.
- wb_ack_i and wb_err_i asserted in the same cycle -> error path wins: err_timeout=0, data_rd_data=ERR_RDATA. Separately, an ack in the expiry cycle completes normally with no error.
- Zero-mask write -> no cyc assertion; data_ack one cycle after sampling.
- 260 forced errors -> err_count saturates at 255.
- rstz pulsed low mid-BUS -> cyc drops asynchronously; no data_ack; next request runs normally.

Source files
------------

// File: rtl/kronos_dbus_bridge.sv
// Kronos data-port to Wishbone-classic master bridge.
// Adds a bus timeout, error reporting, and local completion of zero-mask writes.
module kronos_dbus_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rstz,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wr_data,
  input  logic [3:0]  data_mask,
  input  logic        data_wr_en,
  input  logic        data_req,
  output logic        data_ack,
  output logic [31:0] data_rd_data,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  output logic        err_vld,
  output logic [31:0] err_addr,
  output logic        err_timeout,
  output logic [7:0]  err_count
);

  // A disabled timeout still needs a 1-bit counter to keep the width legal.
  localparam int unsigned CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t        state, state_next;
  logic [CW-1:0] tmo_cnt;
  logic          start_bus, zero_write, done_ok, done_err, timed_out;

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    start_bus  = 1'b0;
    zero_write = 1'b0;
    done_ok    = 1'b0;
    done_err   = 1'b0;
    timed_out  = 1'b0;
    case (state)
      IDLE: begin
        if (data_req) begin
          if (data_wr_en && data_mask == 4'b0000) begin
            zero_write = 1'b1;
            state_next = RESP;
          end else begin
            start_bus  = 1'b1;
            state_next = BUS;
          end
        end
      end
      BUS: begin
        // A slave error outranks an ack in the same cycle; an ack outranks expiry.
        if (wb_err_i) begin
          done_err   = 1'b1;
          state_next = RESP;
        end else if (wb_ack_i) begin
          done_ok    = 1'b1;
          state_next = RESP;
        end else if (TIMEOUT_CYCLES != 0 && tmo_cnt == TMO_LAST) begin
          done_err   = 1'b1;
          timed_out  = 1'b1;
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign data_ack = (state == RESP);
  assign wb_stb_o = wb_cyc_o;

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      wb_adr_o     <= '0;
      wb_dat_o     <= '0;
      wb_sel_o     <= '0;
      wb_we_o      <= 1'b0;
      wb_cyc_o     <= 1'b0;
      tmo_cnt      <= '0;
      data_rd_data <= '0;
      err_vld      <= 1'b0;
      err_addr     <= '0;
      err_timeout  <= 1'b0;
      err_count    <= '0;
    end else begin
      err_vld <= done_err;
      if (start_bus) begin
        wb_adr_o <= {data_addr[31:2], 2'b00};
        wb_dat_o <= data_wr_data;
        wb_sel_o <= data_mask;
        wb_we_o  <= data_wr_en;
        wb_cyc_o <= 1'b1;
        tmo_cnt  <= '0;
      end else if (state == BUS) begin
        tmo_cnt <= tmo_cnt + CW'(1);
      end
      if (done_ok || done_err) wb_cyc_o <= 1'b0;
      if (zero_write) data_rd_data <= '0;
      if (done_ok)    data_rd_data <= wb_we_o ? 32'h0 : wb_dat_i;
      if (done_err) begin
        data_rd_data <= ERR_RDATA;
        err_addr     <= data_addr;
        err_timeout  <= timed_out;
        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
      end
    end
  end

endmodule
